// File: rtl/op_timeline_issuer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | op_timeline_issuer_if : instruction-memory read port and timed-FIFO push |
// | port of the op timeline issuer.                                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface op_timeline_issuer_if #(
   parameter int IMEM_AW = 10
);
   logic               o_imem_en;
   logic [IMEM_AW-1:0] o_imem_addr;
   logic [31:0]        i_imem_data;
   logic               i_fifo_full;
   logic [19:0]        o_fifo_time;
   logic [17:0]        o_fifo_op;
   logic               o_fifo_we;

   modport master (
      output o_imem_en, o_imem_addr, o_fifo_time, o_fifo_op, o_fifo_we,
      input  i_imem_data, i_fifo_full
   );

   modport slave (
      input  o_imem_en, o_imem_addr, o_fifo_time, o_fifo_op, o_fifo_we,
      output i_imem_data, i_fifo_full
   );
endinterface
`default_nettype wire

// File: rtl/op_timeline_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | op_timeline_issuer : fetches program words, keeps a 20-bit timeline and  |
// | pushes {time, op} into the timed FIFO. Option: OP_TIMELINE_LATE_DROP_EN. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module op_timeline_issuer #(
   parameter int          IMEM_AW    = 10,
   parameter logic [19:0] START_LEAD = 20'd64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_start,
   input  logic [IMEM_AW-1:0]  i_base_addr,
   input  logic                i_abort,
   input  logic [19:0]         t_cnt,
   op_timeline_issuer_if.master bus,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_late,
   output logic [15:0]         o_push_cnt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_DECODE = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   localparam logic [1:0]         OPC_SYNC = 2'b00;
   localparam logic [1:0]         OPC_QOP  = 2'b01;
   localparam logic [1:0]         OPC_WAIT = 2'b10;
   localparam logic [IMEM_AW-1:0] PC_STEP  = 1;

   state_t             state_q, state_d;
   logic [IMEM_AW-1:0] pc_q, pc_d;
   logic [19:0]        tl_q, tl_d;
   logic [19:0]        hold_time_q, hold_time_d;
   logic [17:0]        hold_op_q, hold_op_d;
   logic               late_q, late_d;
   logic [15:0]        cnt_q, cnt_d;

   logic [1:0]  w_opcode;
   logic [19:0] w_d20;
   logic [19:0] w_qop_time;
   logic [19:0] w_cand_time;
   logic [19:0] w_slack;
   logic        w_cand_late;
   logic        w_push;

   assign w_opcode    = bus.i_imem_data[31:30];
   assign w_d20       = bus.i_imem_data[19:0];
   assign w_qop_time  = tl_q + {8'd0, bus.i_imem_data[29:18]};
   assign w_cand_time = (state_q == S_HOLD) ? hold_time_q : w_qop_time;
   // Late when the slack to the current time is zero or negative (mod 2^20).
   assign w_slack     = w_cand_time - t_cnt;
   assign w_cand_late = (w_slack == 20'd0) || w_slack[19];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         tl_q        <= '0;
         hold_time_q <= '0;
         hold_op_q   <= '0;
         late_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         tl_q        <= tl_d;
         hold_time_q <= hold_time_d;
         hold_op_q   <= hold_op_d;
         late_q      <= late_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      tl_d            = tl_q;
      hold_time_d     = hold_time_q;
      hold_op_d       = hold_op_q;
      late_d          = late_q;
      cnt_d           = cnt_q;
      w_push          = 1'b0;
      bus.o_imem_en   = 1'b0;
      bus.o_imem_addr = '0;
      bus.o_fifo_time = '0;
      bus.o_fifo_op   = '0;
      bus.o_fifo_we   = 1'b0;
      o_done          = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               pc_d    = i_base_addr;
               tl_d    = t_cnt + START_LEAD;
               late_d  = 1'b0;
               cnt_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            bus.o_imem_en   = 1'b1;
            bus.o_imem_addr = pc_q;
            pc_d            = pc_q + PC_STEP;
            state_d         = S_DECODE;
         end
         S_DECODE: begin
            case (w_opcode)
               OPC_SYNC: begin
                  tl_d    = t_cnt + w_d20;
                  state_d = S_FETCH;
               end
               OPC_QOP: begin
                  tl_d            = w_qop_time;
                  bus.o_fifo_time = w_qop_time;
                  bus.o_fifo_op   = bus.i_imem_data[17:0];
                  if (bus.i_fifo_full) begin
                     hold_time_d = w_qop_time;
                     hold_op_d   = bus.i_imem_data[17:0];
                     state_d     = S_HOLD;
                  end else begin
                     w_push  = 1'b1;
                     state_d = S_FETCH;
                  end
               end
               OPC_WAIT: begin
                  tl_d    = tl_q + w_d20;
                  state_d = S_FETCH;
               end
               default: begin
                  o_done  = 1'b1;
                  state_d = S_IDLE;
               end
            endcase
         end
         S_HOLD: begin
            bus.o_fifo_time = hold_time_q;
            bus.o_fifo_op   = hold_op_q;
            if (!bus.i_fifo_full) begin
               w_push  = 1'b1;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (w_push) begin
         if (w_cand_late) begin
            late_d = 1'b1;
         end
`ifdef OP_TIMELINE_LATE_DROP_EN
         if (!w_cand_late) begin
            bus.o_fifo_we = 1'b1;
            cnt_d         = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
         end
`else
         bus.o_fifo_we = 1'b1;
         cnt_d         = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
`endif
      end

      // Abort overrides everything: no push, no done, status counters frozen.
      if (i_abort) begin
         state_d         = S_IDLE;
         pc_d            = pc_q;
         tl_d            = tl_q;
         hold_time_d     = hold_time_q;
         hold_op_d       = hold_op_q;
         late_d          = late_q;
         cnt_d           = cnt_q;
         bus.o_imem_en   = 1'b0;
         bus.o_imem_addr = '0;
         bus.o_fifo_we   = 1'b0;
         o_done          = 1'b0;
      end
   end

   assign o_busy     = (state_q != S_IDLE);
   assign o_late     = late_q;
   assign o_push_cnt = cnt_q;

endmodule
`default_nettype wire
